// File: rtl/thermostat_pkg.sv
// Shared encodings for the thermostat controller: FSM states and operating modes.
package thermostat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_HEAT = 2'd1;
    localparam logic [1:0] MODE_COOL = 2'd2;
    localparam logic [1:0] MODE_AUTO = 2'd3;

endpackage

// File: rtl/dwell_timer.sv
// Minimum-dwell timer: reloads to MIN_DWELL-1 on every state transition and
// counts down to zero; while nonzero it blocks normal (non-forced) transitions.
module dwell_timer #(
    parameter int unsigned MIN_DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);

    logic [7:0] cnt_q;

    // Reload on transition, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= 8'(MIN_DWELL - 1);
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign active = (cnt_q != 8'd0);

endmodule

// File: rtl/thermostat_ctrl.sv
// Registered hysteresis thermostat with runtime setpoint/hysteresis, mode gating,
// forced shutdown on mode change and a compressor-protection dwell timer.
module thermostat_ctrl
    import thermostat_pkg::*;
#(
    parameter int unsigned TEMP_W       = 5,
    parameter int unsigned MIN_DWELL    = 4,
    parameter int unsigned DEF_SETPOINT = 20,
    parameter int unsigned DEF_HYST     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temperature,
    input  logic [1:0]        mode,
    input  logic              cfg_we,
    input  logic [TEMP_W-1:0] cfg_setpoint,
    input  logic [TEMP_W-1:0] cfg_hyst,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              dwell_active
);

    localparam logic [TEMP_W-1:0] TempMax = '1;

    state_e            state_q, state_d;
    logic              heating_q, cooling_q;
    logic [TEMP_W-1:0] setpoint_q, hyst_q;
    logic [TEMP_W-1:0] thr_lo, thr_hi;
    logic [TEMP_W:0]   hi_sum;
    logic              heat_ok, cool_ok, forced_idle, load;

    // Saturating thresholds so the extremes of the temperature range still trigger.
    always_comb begin
        hi_sum = {1'b0, setpoint_q} + {1'b0, hyst_q};
        thr_lo = (setpoint_q >= hyst_q) ? (setpoint_q - hyst_q) : '0;
        thr_hi = (hi_sum > {1'b0, TempMax}) ? TempMax : hi_sum[TEMP_W-1:0];
    end

    // Next-state decision: forced exits first, then dwell-gated hysteresis.
    always_comb begin
        state_d     = state_q;
        heat_ok     = (mode == MODE_HEAT) || (mode == MODE_AUTO);
        cool_ok     = (mode == MODE_COOL) || (mode == MODE_AUTO);
        forced_idle = ((state_q == ST_HEAT) && !heat_ok) ||
                      ((state_q == ST_COOL) && !cool_ok);
        if (forced_idle) begin
            state_d = ST_IDLE;
        end else if (!dwell_active) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Heat wins when hyst=0 makes both conditions true.
                    if ((temperature <= thr_lo) && heat_ok) begin
                        state_d = ST_HEAT;
                    end else if ((temperature >= thr_hi) && cool_ok) begin
                        state_d = ST_COOL;
                    end
                end
                ST_HEAT: if (temperature >= setpoint_q) state_d = ST_IDLE;
                ST_COOL: if (temperature <= setpoint_q) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        load = (state_d != state_q);
    end

    // State, drive outputs and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            heating_q  <= 1'b0;
            cooling_q  <= 1'b0;
            setpoint_q <= TEMP_W'(DEF_SETPOINT);
            hyst_q     <= TEMP_W'(DEF_HYST);
        end else begin
            state_q   <= state_d;
            heating_q <= (state_d == ST_HEAT);
            cooling_q <= (state_d == ST_COOL);
            if (cfg_we) begin
                setpoint_q <= cfg_setpoint;
                hyst_q     <= cfg_hyst;
            end
        end
    end

    dwell_timer #(
        .MIN_DWELL(MIN_DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .active(dwell_active)
    );

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign state   = state_q;

endmodule
